// File: rtl/imem_boot_loader.sv
// -----------------------------------------------------------------------------
// imem_boot_loader
//   Loads a program from a little-endian byte stream into the word-addressed
//   instruction store. Once the load is finished it hands the store's read port
//   back to the CPU fetch path. The core is stalled while a load is in progress.
//
//   Optional feature (compile-time macro IMEM_LOADER_CHECKSUM_EN):
//     defined     -> checksum is the running XOR of the words written by the
//                    latest load. It is cleared when a load starts.
//     not defined -> checksum is tied to zero and has no accumulator.
//
// Ports
//   clk, rst        clock (rising edge), asynchronous active-high reset
//   start, load_len one-cycle load request and its word count
//   byte_valid/byte_data/byte_ready   loader byte stream handshake
//   cpu_pc, cpu_instr, cpu_stall      core fetch interface
//   imem_we/imem_waddr/imem_wdata     registered write port to the store
//   imem_raddr/imem_rdata             combinational read port of the store
//   done            one-cycle pulse when a load completes
//   err             sticky: oversize load_len or bad fetch address
//   checksum        XOR of the words written by the last load
// -----------------------------------------------------------------------------
module imem_boot_loader #(
  parameter int          DEPTH    = 32,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [$clog2(DEPTH):0]     load_len,
  input  logic                       byte_valid,
  input  logic [7:0]                 byte_data,
  output logic                       byte_ready,
  input  logic [31:0]                cpu_pc,
  output logic [31:0]                cpu_instr,
  output logic                       cpu_stall,
  output logic                       imem_we,
  output logic [$clog2(DEPTH)-1:0]   imem_waddr,
  output logic [31:0]                imem_wdata,
  output logic [$clog2(DEPTH)-1:0]   imem_raddr,
  input  logic [31:0]                imem_rdata,
  output logic                       done,
  output logic                       err,
  output logic [31:0]                checksum
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [29:0]   DEPTH_W = 30'(DEPTH);

  typedef enum logic [1:0] {S_RUN, S_LOAD, S_FLUSH} state_t;

  state_t          state, state_nx;
  logic [LW-1:0]   len_q;
  logic [LW-1:0]   word_cnt;
  logic [1:0]      byte_cnt;
  logic [23:0]     asm_q;

  logic            accept;
  logic            last_byte;
  logic            last_word;
  logic            fetch_bad;
  logic            start_acc;
  logic [31:0]     word_asm;

  // Requests longer than the store are clamped to the store size.
  function automatic logic [LW-1:0] sat_len(input logic [LW-1:0] req);
    return (req > DEPTH_L) ? DEPTH_L : req;
  endfunction

  assign accept    = byte_valid && byte_ready;
  assign last_byte = accept && (byte_cnt == 2'd3);
  assign last_word = last_byte && ((word_cnt + LW'(1)) == len_q);
  assign fetch_bad = (cpu_pc[1:0] != 2'b00) || (cpu_pc[31:2] >= DEPTH_W);
  assign start_acc = (state == S_RUN) && start;
  assign word_asm  = {byte_data, asm_q};

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN:   if (start) state_nx = (load_len == '0) ? S_FLUSH : S_LOAD;
      S_LOAD:  if (last_word) state_nx = S_FLUSH;
      S_FLUSH: state_nx = S_RUN;
      default: state_nx = S_RUN;
    endcase
  end

  assign byte_ready = (state == S_LOAD);
  assign cpu_stall  = (state != S_RUN);
  assign done       = (state == S_FLUSH);
  assign imem_raddr = cpu_pc[AW+1:2];
  assign cpu_instr  = ((state == S_RUN) && !fetch_bad) ? imem_rdata : NOP_WORD;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_RUN;
      len_q    <= '0;
      word_cnt <= '0;
      byte_cnt <= '0;
      asm_q    <= '0;
      imem_we  <= 1'b0;
      err      <= 1'b0;
    end else begin
      state   <= state_nx;
      imem_we <= last_byte;
      if (start_acc) begin
        len_q    <= sat_len(load_len);
        word_cnt <= '0;
        byte_cnt <= '0;
        if (load_len > DEPTH_L) err <= 1'b1;
      end
      if ((state == S_RUN) && fetch_bad) err <= 1'b1;
      if (accept) begin
        byte_cnt <= byte_cnt + 2'd1;
        case (byte_cnt)
          2'd0:    asm_q[7:0]   <= byte_data;
          2'd1:    asm_q[15:8]  <= byte_data;
          2'd2:    asm_q[23:16] <= byte_data;
          default: word_cnt     <= word_cnt + LW'(1);
        endcase
      end
    end
  end

  // Write stage: address/data are captured alongside imem_we and need no reset.
  always_ff @(posedge clk) begin
    if (last_byte) begin
      imem_waddr <= word_cnt[AW-1:0];
      imem_wdata <= word_asm;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0] csum_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else if (start_acc) begin
      csum_q <= '0;
    end else if (last_byte) begin
      csum_q <= csum_q ^ word_asm;
    end
  end

  assign checksum = csum_q;
`else
  assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_imem_boot_loader.sv
module tb_imem_boot_loader;

  localparam int          DEPTH = 32;
  localparam int          AW    = $clog2(DEPTH);
  localparam int          LW    = AW + 1;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [LW-1:0]   load_len;
  logic            byte_valid;
  logic [7:0]      byte_data;
  logic            byte_ready;
  logic [31:0]     cpu_pc;
  logic [31:0]     cpu_instr;
  logic            cpu_stall;
  logic            imem_we;
  logic [AW-1:0]   imem_waddr;
  logic [31:0]     imem_wdata;
  logic [AW-1:0]   imem_raddr;
  logic [31:0]     imem_rdata;
  logic            done;
  logic            err;
  logic [31:0]     checksum;

  int checks = 0;
  int errors = 0;

  // Instruction store behind the loader
  logic [31:0] mem [DEPTH];
  int          we_cnt = 0;

  always @(posedge clk) begin
    if (imem_we) begin
      mem[imem_waddr] <= imem_wdata;
      we_cnt <= we_cnt + 1;
    end
  end
  assign imem_rdata = mem[imem_raddr];

  // Reference model state
  logic [31:0] exp_mem [DEPTH];
  bit          exp_known [DEPTH];
  bit          exp_err;
  logic [31:0] exp_csum;
  logic [7:0]  bq [$];

  always #5 clk = ~clk;

  imem_boot_loader #(.DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .cpu_pc(cpu_pc), .cpu_instr(cpu_instr), .cpu_stall(cpu_stall),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .imem_raddr(imem_raddr), .imem_rdata(imem_rdata),
    .done(done), .err(err), .checksum(checksum)
  );

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; byte_valid = 1'b0; cpu_pc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    exp_err  = 1'b0;
    exp_csum = 32'h0;
  endtask

  // Runs one load of len_in words from bq. mode: 0 always valid, 1 toggled, 2 random gaps.
  task automatic run_load(input string tag, input int len_in, input int mode, input bit poke_start);
    int n, idx, cyc, we0, bad_stall, bad_instr, bad_ready;
    bit seen_done;
    logic [31:0] w, cs;
    n = (len_in > DEPTH) ? DEPTH : len_in;
    if (len_in > DEPTH) exp_err = 1'b1;
    cs = 32'h0;
    for (int i = 0; i < n; i++) begin
      w = {bq[4*i+3], bq[4*i+2], bq[4*i+1], bq[4*i]};
      exp_mem[i] = w;
      exp_known[i] = 1'b1;
      cs = cs ^ w;
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_csum = cs;
`else
    exp_csum = 32'h0;
`endif
    we0 = we_cnt;
    @(negedge clk);
    start = 1'b1; load_len = LW'(len_in); byte_valid = 1'b0; cpu_pc = 32'h4;
    idx = 0; cyc = 0; seen_done = 1'b0;
    bad_stall = 0; bad_instr = 0; bad_ready = 0;
    while (!seen_done && cyc < 3000) begin
      @(negedge clk);
      start    = poke_start && (cyc == 3);
      load_len = LW'(1);
      case (mode)
        0:       byte_valid = (idx < bq.size());
        1:       byte_valid = (idx < bq.size()) && (cyc % 2 == 0);
        default: byte_valid = (idx < bq.size()) && ($urandom_range(0, 99) < 60);
      endcase
      byte_data = byte_valid ? bq[idx] : 8'($urandom);
      #1;
      if (cpu_stall !== 1'b1) bad_stall++;
      if (cpu_instr !== NOP) bad_instr++;
      if (done === 1'b1) begin
        seen_done = 1'b1;
        if (byte_ready !== 1'b0) bad_ready++;
      end
      if (byte_valid && byte_ready) idx++;
      cyc++;
    end
    checks++;
    if (!seen_done) begin
      errors++;
      $display("FAIL %s done_timeout: no done pulse within %0d cycles", tag, cyc);
    end
    checks++;
    if (bad_stall != 0) begin
      errors++;
      $display("FAIL %s stall_during_load: %0d cycles with cpu_stall low, need 0", tag, bad_stall);
    end
    checks++;
    if (bad_instr != 0) begin
      errors++;
      $display("FAIL %s nop_during_load: %0d cycles with cpu_instr != NOP, need 0", tag, bad_instr);
    end
    checks++;
    if (bad_ready != 0) begin
      errors++;
      $display("FAIL %s ready_in_flush: byte_ready high during done cycle", tag);
    end
    @(negedge clk);
    start = 1'b0; byte_valid = 1'b0;
    #1;
    checks++;
    if (done !== 1'b0 || cpu_stall !== 1'b0 || byte_ready !== 1'b0) begin
      errors++;
      $display("FAIL %s after_flush: done=%b stall=%b ready=%b, need 0 0 0", tag, done, cpu_stall, byte_ready);
    end
    @(negedge clk);
    checks++;
    if (we_cnt - we0 != n) begin
      errors++;
      $display("FAIL %s write_count: got %0d need %0d", tag, we_cnt - we0, n);
    end
    checks++;
    if (idx != 4 * n) begin
      errors++;
      $display("FAIL %s bytes_taken: got %0d need %0d", tag, idx, 4 * n);
    end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (mem[i] !== exp_mem[i]) begin
        errors++;
        $display("FAIL %s imem[%0d]: got %h need %h", tag, i, mem[i], exp_mem[i]);
      end
    end
    checks++;
    if (err !== exp_err) begin
      errors++;
      $display("FAIL %s err: got %b need %b", tag, err, exp_err);
    end
    checks++;
    if (checksum !== exp_csum) begin
      errors++;
      $display("FAIL %s checksum: got %h need %h", tag, checksum, exp_csum);
    end
  endtask

  task automatic fill_random(input int nbytes);
    bq.delete();
    for (int i = 0; i < nbytes; i++) bq.push_back(8'($urandom));
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; load_len = '0; byte_valid = 1'b0; byte_data = 8'h0; cpu_pc = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0; exp_csum = 32'h0;
    #1;
    checks++;
    if (byte_ready !== 1'b0 || cpu_stall !== 1'b0 || imem_we !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ready=%b stall=%b we=%b done=%b, need all 0", byte_ready, cpu_stall, imem_we, done);
    end
    checks++;
    if (err !== 1'b0 || checksum !== 32'h0) begin
      errors++;
      $display("FAIL reset_status: err=%b checksum=%h, need 0 and 0", err, checksum);
    end
  endtask

  task automatic test_basic_load();
    bq = '{8'h93, 8'h02, 8'h40, 8'h00, 8'h13, 8'h03, 8'h50, 8'h00};
    run_load("basic", 2, 0, 1'b0);
  endtask

  task automatic test_toggled_valid();
    bq = '{8'h93, 8'h02, 8'h40, 8'h00, 8'h13, 8'h03, 8'h50, 8'h00};
    run_load("toggle", 2, 1, 1'b0);
    fill_random(12);
    run_load("toggle_rand", 3, 1, 1'b1);
  endtask

  task automatic test_zero_len();
    bq.delete();
    run_load("zero_len", 0, 0, 1'b0);
  endtask

  task automatic test_random_loads();
    int len;
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, 8);
      fill_random(4 * len);
      run_load("random", len, $urandom_range(0, 2), k[0]);
    end
  endtask

  task automatic test_fetch();
    int a;
    @(negedge clk);
    cpu_pc = 32'h4;
    #1;
    checks++;
    if (cpu_instr !== exp_mem[1]) begin
      errors++;
      $display("FAIL fetch_pc4: got %h need %h", cpu_instr, exp_mem[1]);
    end
    for (int k = 0; k < 8; k++) begin
      a = $urandom_range(0, DEPTH - 1);
      if (exp_known[a]) begin
        @(negedge clk);
        cpu_pc = 32'(a * 4);
        #1;
        checks++;
        if (cpu_instr !== exp_mem[a]) begin
          errors++;
          $display("FAIL fetch_rand[%0d]: got %h need %h", a, cpu_instr, exp_mem[a]);
        end
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL fetch_no_err: err=%b need 0", err);
    end
    @(negedge clk);
    cpu_pc = 32'h6;
    #1;
    checks++;
    if (cpu_instr !== NOP) begin
      errors++;
      $display("FAIL fetch_misaligned: got %h need %h", cpu_instr, NOP);
    end
    @(negedge clk);
    cpu_pc = 32'h0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_misaligned: err=%b need 1", err);
    end
    do_reset();
    @(negedge clk);
    cpu_pc = 32'h80;
    #1;
    checks++;
    if (cpu_instr !== NOP) begin
      errors++;
      $display("FAIL fetch_oob: got %h need %h", cpu_instr, NOP);
    end
    @(negedge clk);
    cpu_pc = 32'h0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_oob: err=%b need 1", err);
    end
    do_reset();
    @(negedge clk);
    cpu_pc = 32'h8000_0004;
    #1;
    checks++;
    if (cpu_instr !== NOP) begin
      errors++;
      $display("FAIL fetch_high_pc: got %h need %h", cpu_instr, NOP);
    end
    do_reset();
  endtask

  task automatic test_overlength();
    fill_random(4 * 40);
    run_load("overlen", 40, 2, 1'b0);
    do_reset();
  endtask

  task automatic test_reset_midload();
    int idx, cyc, dones;
    bq = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    run_load("preload", 2, 0, 1'b0);
    fill_random(8);
    @(negedge clk);
    start = 1'b1; load_len = LW'(2); byte_valid = 1'b0;
    idx = 0; cyc = 0; dones = 0;
    while (idx < 5 && cyc < 100) begin
      @(negedge clk);
      start = 1'b0;
      byte_valid = 1'b1;
      byte_data = bq[idx];
      #1;
      if (done === 1'b1) dones++;
      if (byte_ready) idx++;
      cyc++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (done === 1'b1) dones++;
    rst = 1'b1;
    #1;
    checks++;
    if (cpu_stall !== 1'b0 || byte_ready !== 1'b0 || done !== 1'b0 || imem_we !== 1'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: stall=%b ready=%b done=%b we=%b, need 0", cpu_stall, byte_ready, done, imem_we);
    end
    @(negedge clk);
    rst = 1'b0;
    exp_err = 1'b0;
    exp_mem[0] = {bq[3], bq[2], bq[1], bq[0]};
    repeat (2) begin
      @(negedge clk);
      #1;
      if (done === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL midrst_done: %0d done pulses, need 0", dones);
    end
    checks++;
    if (mem[0] !== exp_mem[0]) begin
      errors++;
      $display("FAIL midrst_word0: got %h need %h", mem[0], exp_mem[0]);
    end
    checks++;
    if (mem[1] !== exp_mem[1]) begin
      errors++;
      $display("FAIL midrst_word1: got %h need %h", mem[1], exp_mem[1]);
    end
    checks++;
    if (cpu_stall !== 1'b0 || checksum !== 32'h0) begin
      errors++;
      $display("FAIL midrst_run: stall=%b checksum=%h, need 0 and 0", cpu_stall, checksum);
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) exp_known[i] = 1'b0;
    test_reset();
    test_basic_load();
    test_toggled_valid();
    test_zero_len();
    test_random_loads();
    test_fetch();
    test_overlength();
    test_reset_midload();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
